// File: rtl/in_switch_flex.sv
// Input-side lane switch: deals a shared g/h stream pair out to two compute lanes in
// ping-pong bursts, joined {g,h} in WIDE mode or h-only in NARROW mode.
module in_switch_flex #(
  parameter int DATA_G_W = 1280,
  parameter int DATA_H_W = 256,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic                         cfg_mode,
  input  logic [CNT_W-1:0]             cfg_len,
  input  logic [CNT_W-1:0]             cfg_swap,
  input  logic                         cfg_first_dst,
  input  logic [DATA_G_W-1:0]          s_axis_g_tdata,
  input  logic                         s_axis_g_tvalid,
  output logic                         s_axis_g_tready,
  input  logic [DATA_H_W-1:0]          s_axis_h_tdata,
  input  logic                         s_axis_h_tvalid,
  output logic                         s_axis_h_tready,
  output logic [DATA_G_W+DATA_H_W-1:0] m_axis_tdata_0,
  output logic                         m_axis_tvalid_0,
  input  logic                         m_axis_tready_0,
  output logic [DATA_G_W+DATA_H_W-1:0] m_axis_tdata_1,
  output logic                         m_axis_tvalid_1,
  input  logic                         m_axis_tready_1,
  output logic [DATA_H_W-1:0]          m_axis_256_tdata_0,
  output logic                         m_axis_256_tvalid_0,
  input  logic                         m_axis_256_tready_0,
  output logic [DATA_H_W-1:0]          m_axis_256_tdata_1,
  output logic                         m_axis_256_tvalid_1,
  input  logic                         m_axis_256_tready_1,
  output logic                         busy,
  output logic                         done
);

  localparam int DATA_W = DATA_G_W + DATA_H_W;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  swap_q, swap_d;
  logic              dst_q, dst_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  swap_cnt_q, swap_cnt_d;
  logic              done_q, done_d;

  logic [1:0]          w_valid_q, w_valid_d;
  logic [DATA_W-1:0]   w_data_q [2];
  logic [DATA_W-1:0]   w_data_d [2];
  logic [1:0]          n_valid_q, n_valid_d;
  logic [DATA_H_W-1:0] n_data_q [2];
  logic [DATA_H_W-1:0] n_data_d [2];

  logic [1:0] w_tready_s, n_tready_s;
  logic [1:0] w_free_s, n_free_s;
  logic [1:0] w_load_s, n_load_s;
  logic       acc_s, g_ready_s, h_ready_s;

  assign w_tready_s = {m_axis_tready_1, m_axis_tready_0};
  assign n_tready_s = {m_axis_256_tready_1, m_axis_256_tready_0};
  assign w_free_s   = ~w_valid_q | w_tready_s;
  assign n_free_s   = ~n_valid_q | n_tready_s;

  // Job FSM: descriptor latch, join/accept decision, beat and swap counting
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    swap_d     = swap_q;
    dst_d      = dst_q;
    beat_cnt_d = beat_cnt_q;
    swap_cnt_d = swap_cnt_q;
    done_d     = 1'b0;
    acc_s      = 1'b0;
    g_ready_s  = 1'b0;
    h_ready_s  = 1'b0;
    w_load_s   = 2'b00;
    n_load_s   = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          mode_d     = cfg_mode;
          len_d      = cfg_len;
          swap_d     = cfg_swap;
          dst_d      = cfg_first_dst;
          beat_cnt_d = CNT_ZERO;
          swap_cnt_d = CNT_ZERO;
          if (cfg_len == CNT_ZERO) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (mode_q) begin
          // Both readies depend on both valids so neither stream is consumed alone.
          acc_s           = s_axis_g_tvalid & s_axis_h_tvalid & w_free_s[dst_q];
          g_ready_s       = acc_s;
          h_ready_s       = acc_s;
          w_load_s[dst_q] = acc_s;
        end else begin
          h_ready_s       = n_free_s[dst_q];
          acc_s           = s_axis_h_tvalid & n_free_s[dst_q];
          n_load_s[dst_q] = acc_s;
        end
        if (acc_s) begin
          beat_cnt_d = beat_cnt_q + CNT_ONE;
          if ((swap_q != CNT_ZERO) && (swap_cnt_q == swap_q - CNT_ONE)) begin
            swap_cnt_d = CNT_ZERO;
            dst_d      = ~dst_q;
          end else begin
            swap_cnt_d = swap_cnt_q + CNT_ONE;
          end
          if (beat_cnt_q == len_q - CNT_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Forward slices: reload wins over drain, otherwise drain on tready
  always_comb begin
    w_valid_d = w_valid_q;
    w_data_d  = w_data_q;
    n_valid_d = n_valid_q;
    n_data_d  = n_data_q;
    for (int p = 0; p < 2; p++) begin
      if (w_load_s[p]) begin
        w_valid_d[p] = 1'b1;
        w_data_d[p]  = {s_axis_g_tdata, s_axis_h_tdata};
      end else if (w_tready_s[p]) begin
        w_valid_d[p] = 1'b0;
      end else begin
        w_valid_d[p] = w_valid_q[p];
      end
      if (n_load_s[p]) begin
        n_valid_d[p] = 1'b1;
        n_data_d[p]  = s_axis_h_tdata;
      end else if (n_tready_s[p]) begin
        n_valid_d[p] = 1'b0;
      end else begin
        n_valid_d[p] = n_valid_q[p];
      end
    end
  end

  // State, counters and output slice registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      len_q      <= CNT_ZERO;
      swap_q     <= CNT_ZERO;
      dst_q      <= 1'b0;
      beat_cnt_q <= CNT_ZERO;
      swap_cnt_q <= CNT_ZERO;
      done_q     <= 1'b0;
      w_valid_q  <= 2'b00;
      n_valid_q  <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        w_data_q[p] <= {DATA_W{1'b0}};
        n_data_q[p] <= {DATA_H_W{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      swap_q     <= swap_d;
      dst_q      <= dst_d;
      beat_cnt_q <= beat_cnt_d;
      swap_cnt_q <= swap_cnt_d;
      done_q     <= done_d;
      w_valid_q  <= w_valid_d;
      n_valid_q  <= n_valid_d;
      for (int p = 0; p < 2; p++) begin
        w_data_q[p] <= w_data_d[p];
        n_data_q[p] <= n_data_d[p];
      end
    end
  end

  assign cfg_ready           = (state_q == ST_IDLE);
  assign busy                = (state_q == ST_RUN);
  assign done                = done_q;
  assign s_axis_g_tready     = g_ready_s;
  assign s_axis_h_tready     = h_ready_s;
  assign m_axis_tdata_0      = w_data_q[0];
  assign m_axis_tdata_1      = w_data_q[1];
  assign m_axis_tvalid_0     = w_valid_q[0];
  assign m_axis_tvalid_1     = w_valid_q[1];
  assign m_axis_256_tdata_0  = n_data_q[0];
  assign m_axis_256_tdata_1  = n_data_q[1];
  assign m_axis_256_tvalid_0 = n_valid_q[0];
  assign m_axis_256_tvalid_1 = n_valid_q[1];

endmodule

// File: tb/tb_in_switch_flex.sv
// Directed bench for in_switch_flex: table of burst jobs plus hand sequences for join skew,
// backpressure, zero-length jobs and mid-job reset.
module tb_in_switch_flex;

  localparam int GW = 1280;
  localparam int HW = 256;
  localparam int DW = GW + HW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid, cfg_ready, cfg_mode, cfg_first_dst;
  logic [15:0]   cfg_len, cfg_swap;
  logic [GW-1:0] g_data;
  logic          g_valid, g_ready;
  logic [HW-1:0] h_data;
  logic          h_valid, h_ready;
  logic [DW-1:0] w_data0, w_data1;
  logic          w_valid0, w_valid1, w_ready0, w_ready1;
  logic [HW-1:0] n_data0, n_data1;
  logic          n_valid0, n_valid1, n_ready0, n_ready1;
  logic          busy, done;

  int errors = 0;
  int checks = 0;

  in_switch_flex dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .cfg_len(cfg_len), .cfg_swap(cfg_swap), .cfg_first_dst(cfg_first_dst),
    .s_axis_g_tdata(g_data), .s_axis_g_tvalid(g_valid), .s_axis_g_tready(g_ready),
    .s_axis_h_tdata(h_data), .s_axis_h_tvalid(h_valid), .s_axis_h_tready(h_ready),
    .m_axis_tdata_0(w_data0), .m_axis_tvalid_0(w_valid0), .m_axis_tready_0(w_ready0),
    .m_axis_tdata_1(w_data1), .m_axis_tvalid_1(w_valid1), .m_axis_tready_1(w_ready1),
    .m_axis_256_tdata_0(n_data0), .m_axis_256_tvalid_0(n_valid0), .m_axis_256_tready_0(n_ready0),
    .m_axis_256_tdata_1(n_data1), .m_axis_256_tvalid_1(n_valid1), .m_axis_256_tready_1(n_ready1),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [15:0] len;
    logic [15:0] swap;
    logic        first;
    logic [15:0] lanes;  // bit i = lane expected to receive beat i
  } job_t;

  job_t jobs [6];

  function automatic logic [GW-1:0] gval(input int job, input int i);
    gval = (GW'(i) << 8) | (GW'(job) << 1200);
  endfunction

  function automatic logic [HW-1:0] hval(input int job, input int i);
    hval = HW'(i) | (HW'(job) << 240);
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act[319:0], exp[319:0]);
    end
  endtask

  task automatic set_beat(input int job, input int i);
    g_data = gval(job, i);
    h_data = hval(job, i);
  endtask

  // Sinks always ready, both streams always valid: one beat per cycle from the cycle after cfg.
  task automatic run_job(input int j);
    logic lane;
    int   n;
    n = int'(jobs[j].len);
    @(negedge clk);
    cfg_mode = jobs[j].mode; cfg_len = jobs[j].len; cfg_swap = jobs[j].swap;
    cfg_first_dst = jobs[j].first; cfg_valid = 1'b1;
    g_valid = 1'b1; h_valid = 1'b1; set_beat(j, 0);
    #1 chk("job_cfg_ready", cfg_ready, 1);
    @(posedge clk);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("job_busy", busy, (k < n));
      chk("job_done", done, (k == n));
      if (k == 0) begin
        chk("job_w0_idle", w_valid0, 0); chk("job_w1_idle", w_valid1, 0);
        chk("job_n0_idle", n_valid0, 0); chk("job_n1_idle", n_valid1, 0);
      end else begin
        lane = jobs[j].lanes[k-1];
        chk("job_w0_valid", w_valid0, jobs[j].mode && lane == 1'b0);
        chk("job_w1_valid", w_valid1, jobs[j].mode && lane == 1'b1);
        chk("job_n0_valid", n_valid0, !jobs[j].mode && lane == 1'b0);
        chk("job_n1_valid", n_valid1, !jobs[j].mode && lane == 1'b1);
        if (jobs[j].mode)
          chk("job_w_data", lane ? w_data1 : w_data0, {gval(j, k-1), hval(j, k-1)});
        else
          chk("job_n_data", lane ? n_data1 : n_data0, hval(j, k-1));
      end
      if (k < n) begin
        set_beat(j, k);
        #1;
        chk("job_h_ready", h_ready, 1);
        chk("job_g_ready", g_ready, jobs[j].mode);
      end else begin
        #1;
        chk("job_idle_h_ready", h_ready, 0);
        chk("job_idle_g_ready", g_ready, 0);
        g_valid = 1'b0; h_valid = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("job_drain_w", {w_valid1, w_valid0}, 0);
    chk("job_drain_n", {n_valid1, n_valid0}, 0);
    chk("job_done_once", done, 0);
  endtask

  initial begin
    jobs[0] = '{mode: 1'b1, len: 16'd6, swap: 16'd2, first: 1'b0, lanes: 16'h000C};
    jobs[1] = '{mode: 1'b0, len: 16'd4, swap: 16'd0, first: 1'b1, lanes: 16'h000F};
    jobs[2] = '{mode: 1'b1, len: 16'd5, swap: 16'd1, first: 1'b1, lanes: 16'h0015};
    jobs[3] = '{mode: 1'b0, len: 16'd7, swap: 16'd3, first: 1'b0, lanes: 16'h0038};
    jobs[4] = '{mode: 1'b1, len: 16'd3, swap: 16'd3, first: 1'b0, lanes: 16'h0000};
    jobs[5] = '{mode: 1'b0, len: 16'd2, swap: 16'd5, first: 1'b1, lanes: 16'h0003};

    rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 1'b0; cfg_len = 16'd0; cfg_swap = 16'd0;
    cfg_first_dst = 1'b0; g_data = '0; g_valid = 1'b0; h_data = '0; h_valid = 1'b0;
    w_ready0 = 1'b1; w_ready1 = 1'b1; n_ready0 = 1'b1; n_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valids", {w_valid1, w_valid0, n_valid1, n_valid0}, 0);
    chk("rst_w_data", w_data0 | w_data1, 0);
    chk("rst_n_data", n_data0 | n_data1, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_readies", {g_ready, h_ready}, 0);

    for (int j = 0; j < 6; j++) run_job(j);

    // Join skew: h leads g by 3 cycles
    @(negedge clk);
    cfg_mode = 1'b1; cfg_len = 16'd2; cfg_swap = 16'd0; cfg_first_dst = 1'b0; cfg_valid = 1'b1;
    g_valid = 1'b0; h_valid = 1'b1; set_beat(10, 0);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      #1;
      chk("skew_g_ready_low", g_ready, 0);
      chk("skew_h_ready_low", h_ready, 0);
      chk("skew_no_out", w_valid0, 0);
    end
    @(negedge clk);
    g_valid = 1'b1;
    #1;
    chk("skew_g_ready", g_ready, 1);
    chk("skew_h_ready", h_ready, 1);
    @(negedge clk);
    g_valid = 1'b0; h_valid = 1'b0;
    chk("skew_out_valid", w_valid0, 1);
    chk("skew_out_data", w_data0, {gval(10, 0), hval(10, 0)});
    #1 chk("skew_readies_drop", {g_ready, h_ready}, 0);
    @(negedge clk);
    chk("skew_emitted_once", w_valid0, 0);
    chk("skew_busy", busy, 1);
    g_valid = 1'b1; h_valid = 1'b1; set_beat(10, 1);
    #1 chk("skew_readies_b1", {g_ready, h_ready}, 2'b11);
    @(negedge clk);
    g_valid = 1'b0; h_valid = 1'b0;
    chk("skew_b1_data", w_data0, {gval(10, 1), hval(10, 1)});
    chk("skew_done", done, 1);
    chk("skew_busy_fall", busy, 0);
    @(negedge clk);
    chk("skew_drained", w_valid0, 0);

    // Backpressure on lane 0 with one beat registered
    cfg_mode = 1'b1; cfg_len = 16'd3; cfg_swap = 16'd0; cfg_first_dst = 1'b0; cfg_valid = 1'b1;
    g_valid = 1'b1; h_valid = 1'b1; set_beat(11, 0); w_ready0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    #1 chk("bp_first_ready", {g_ready, h_ready}, 2'b11);
    @(negedge clk);
    chk("bp_loaded", w_valid0, 1);
    set_beat(11, 1);
    #1 chk("bp_ready_low", {g_ready, h_ready}, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", w_valid0, 1);
      chk("bp_hold_data", w_data0, {gval(11, 0), hval(11, 0)});
      if (c < 4) begin
        #1 chk("bp_hold_ready", {g_ready, h_ready}, 0);
      end else begin
        w_ready0 = 1'b1;
        #1 chk("bp_release_ready", {g_ready, h_ready}, 2'b11);
      end
    end
    @(negedge clk);
    chk("bp_reload_valid", w_valid0, 1);
    chk("bp_reload_data", w_data0, {gval(11, 1), hval(11, 1)});
    set_beat(11, 2);
    @(negedge clk);
    chk("bp_last_data", w_data0, {gval(11, 2), hval(11, 2)});
    chk("bp_done", done, 1);
    g_valid = 1'b0; h_valid = 1'b0;
    @(negedge clk);
    chk("bp_drained", w_valid0, 0);

    // Zero-length job, then a job accepted in the done cycle
    cfg_mode = 1'b1; cfg_len = 16'd0; cfg_swap = 16'd0; cfg_first_dst = 1'b0; cfg_valid = 1'b1;
    g_valid = 1'b1; h_valid = 1'b1; set_beat(12, 0);
    @(posedge clk);
    @(negedge clk);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_cfg_ready", cfg_ready, 1);
    chk("len0_readies", {g_ready, h_ready}, 0);
    chk("len0_no_out", {w_valid1, w_valid0, n_valid1, n_valid0}, 0);
    cfg_mode = 1'b0; cfg_len = 16'd1; cfg_swap = 16'd0; cfg_first_dst = 1'b0;
    set_beat(13, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("len0_done_once", done, 0);
    chk("next_busy", busy, 1);
    #1 chk("next_readies", {g_ready, h_ready}, 2'b01);
    @(negedge clk);
    chk("next_n0_valid", n_valid0, 1);
    chk("next_n0_data", n_data0, hval(13, 0));
    chk("next_done", done, 1);
    g_valid = 1'b0; h_valid = 1'b0;
    @(negedge clk);
    chk("next_drained", n_valid0, 0);

    // Reset after 3 of 8 beats
    cfg_mode = 1'b1; cfg_len = 16'd8; cfg_swap = 16'd0; cfg_first_dst = 1'b1; cfg_valid = 1'b1;
    g_valid = 1'b1; h_valid = 1'b1; set_beat(14, 0);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      set_beat(14, c);
    end
    @(negedge clk);
    chk("mid_w1_valid", w_valid1, 1);
    chk("mid_w1_data", w_data1, {gval(14, 2), hval(14, 2)});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valids", {w_valid1, w_valid0, n_valid1, n_valid0}, 0);
    chk("mid_rst_data", w_data1, 0);
    chk("mid_rst_cfg_ready", cfg_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    #1 chk("mid_rst_readies", {g_ready, h_ready}, 0);
    @(negedge clk);
    chk("mid_rst_no_done", done, 0);
    g_valid = 1'b0; h_valid = 1'b0;
    run_job(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
